// File: rtl/spi_cmd_controller_if.sv
// Signal bundle between spi_cmd_controller, the SPI byte channel and the miner.
// The slave modport is the controller's view; master is the environment's view.
interface spi_cmd_controller_if #(
  parameter int HDR_BYTES = 76
);
  localparam int ADDR_W = $clog2(HDR_BYTES);

  // SPI byte channel
  logic              chip_enable;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              tx_req;
  logic [7:0]        tx_byte;

  // Miner status and results
  logic              miner_busy;
  logic              miner_found;
  logic [31:0]       miner_nonce;

  // Job buffer write port and miner controls
  logic              job_we;
  logic [ADDR_W-1:0] job_addr;
  logic [7:0]        job_data;
  logic              job_start;
  logic              miner_abort;

  modport slave (
    input  chip_enable, rx_valid, rx_byte, tx_req,
    input  miner_busy, miner_found, miner_nonce,
    output tx_byte, job_we, job_addr, job_data, job_start, miner_abort
  );

  modport master (
    output chip_enable, rx_valid, rx_byte, tx_req,
    output miner_busy, miner_found, miner_nonce,
    input  tx_byte, job_we, job_addr, job_data, job_start, miner_abort
  );
endinterface

// File: rtl/spi_cmd_controller.sv
// SPI command sequencer for the mining core.
// Decodes chip_enable-delimited frames: LOAD_JOB (0x01) writes HDR_BYTES header
// bytes into the job buffer, READ_STATUS (0x02) shifts out a 5-byte status/nonce
// snapshot, ABORT (0x03) pulses miner_abort. All outputs are registered.
// Optional feature macro: SPI_CMD_CHECKSUM_EN -- LOAD_JOB carries a trailing XOR
// checksum byte that gates job_start.
module spi_cmd_controller #(
  parameter int HDR_BYTES = 76
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_cmd_controller_if.slave  bus
);

  localparam int ADDR_W = $clog2(HDR_BYTES);
  // One extra count so the checksum byte position (HDR_BYTES) is representable.
  localparam int CNT_W  = $clog2(HDR_BYTES + 1);

  localparam logic [7:0] OP_LOAD_JOB    = 8'h01;
  localparam logic [7:0] OP_READ_STATUS = 8'h02;
  localparam logic [7:0] OP_ABORT       = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, LOAD, STATUS, DISCARD} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [2:0]        idx_q, idx_next;
  logic              err_q, err_next;
  logic              found_q, found_next;
  logic              loaded_q, loaded_next;
  logic [31:0]       nonce_q, nonce_next;
  logic              snap;
  logic [7:0]        shadow [5];
  logic [7:0]        status_byte;

  logic [7:0]        tx_byte_q, tx_byte_next;
  logic              job_we_q, job_we_next;
  logic [ADDR_W-1:0] job_addr_q, job_addr_next;
  logic [7:0]        job_data_q, job_data_next;
  logic              job_start_q, job_start_next;
  logic              miner_abort_q, miner_abort_next;

`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_next;
`endif

  assign status_byte = {4'b0000, err_q, found_q, bus.miner_busy, loaded_q};

  assign bus.tx_byte     = tx_byte_q;
  assign bus.job_we      = job_we_q;
  assign bus.job_addr    = job_addr_q;
  assign bus.job_data    = job_data_q;
  assign bus.job_start   = job_start_q;
  assign bus.miner_abort = miner_abort_q;

  // State register.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, datapath and registered-output decode for one frame step.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt_q;
    idx_next         = idx_q;
    err_next         = err_q;
    found_next       = found_q;
    loaded_next      = loaded_q;
    nonce_next       = nonce_q;
    snap             = 1'b0;
    tx_byte_next     = 8'h00;
    job_we_next      = 1'b0;
    job_addr_next    = job_addr_q;
    job_data_next    = job_data_q;
    job_start_next   = 1'b0;
    miner_abort_next = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
    csum_next        = csum_q;
`endif

    if (bus.chip_enable) begin
      // Frame end beats any byte arriving on the same edge.
      state_next = IDLE;
      if (state == LOAD) err_next = 1'b1;
    end else begin
      case (state)
        IDLE: state_next = CMD;

        CMD: begin
          if (bus.rx_valid) begin
            case (bus.rx_byte)
              OP_LOAD_JOB: begin
                state_next = LOAD;
                cnt_next   = '0;
`ifdef SPI_CMD_CHECKSUM_EN
                csum_next  = 8'h00;
`endif
              end
              OP_READ_STATUS: begin
                state_next   = STATUS;
                snap         = 1'b1;
                idx_next     = 3'd0;
                tx_byte_next = status_byte;
              end
              OP_ABORT: begin
                state_next       = DISCARD;
                miner_abort_next = 1'b1;
              end
              default: state_next = DISCARD;
            endcase
          end
        end

        LOAD: begin
          if (bus.rx_valid) begin
`ifdef SPI_CMD_CHECKSUM_EN
            if (cnt_q == CNT_W'(HDR_BYTES)) begin
              state_next = DISCARD;
              if (bus.rx_byte == csum_q) job_start_next = 1'b1;
              else                       err_next       = 1'b1;
            end else begin
              job_we_next   = 1'b1;
              job_addr_next = ADDR_W'(cnt_q);
              job_data_next = bus.rx_byte;
              csum_next     = csum_q ^ bus.rx_byte;
              cnt_next      = cnt_q + 1'b1;
            end
`else
            job_we_next   = 1'b1;
            job_addr_next = ADDR_W'(cnt_q);
            job_data_next = bus.rx_byte;
            cnt_next      = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HDR_BYTES - 1)) state_next = DISCARD;
`endif
          end
        end

        STATUS: begin
          tx_byte_next = shadow[idx_q];
          if (bus.tx_req) begin
            if (idx_q == 3'd4) begin
              state_next   = DISCARD;
              found_next   = 1'b0;
              err_next     = 1'b0;
              tx_byte_next = 8'h00;
            end else begin
              idx_next     = idx_q + 3'd1;
              tx_byte_next = shadow[idx_next];
            end
          end
        end

        DISCARD: state_next = DISCARD;

        default: state_next = IDLE;
      endcase
    end

`ifndef SPI_CMD_CHECKSUM_EN
    // Start follows the cycle in which the last header byte is strobed into the buffer.
    if (job_we_q && (job_addr_q == ADDR_W'(HDR_BYTES - 1))) job_start_next = 1'b1;
`endif

    if (job_start_next)   loaded_next = 1'b1;
    if (miner_abort_next) loaded_next = 1'b0;

    // A found nonce is captured in every state and wins over the readback clear.
    if (bus.miner_found) begin
      nonce_next = bus.miner_nonce;
      found_next = 1'b1;
    end
  end

  // Datapath, flag and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      err_q         <= 1'b0;
      found_q       <= 1'b0;
      loaded_q      <= 1'b0;
      nonce_q       <= 32'h0;
      tx_byte_q     <= 8'h00;
      job_we_q      <= 1'b0;
      job_addr_q    <= '0;
      job_data_q    <= 8'h00;
      job_start_q   <= 1'b0;
      miner_abort_q <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      cnt_q         <= cnt_next;
      idx_q         <= idx_next;
      err_q         <= err_next;
      found_q       <= found_next;
      loaded_q      <= loaded_next;
      nonce_q       <= nonce_next;
      tx_byte_q     <= tx_byte_next;
      job_we_q      <= job_we_next;
      job_addr_q    <= job_addr_next;
      job_data_q    <= job_data_next;
      job_start_q   <= job_start_next;
      miner_abort_q <= miner_abort_next;
`ifdef SPI_CMD_CHECKSUM_EN
      csum_q        <= csum_next;
`endif
    end
  end

  // Readback snapshot taken on the READ_STATUS opcode edge.
  // NOTE: the shadow is not reset; it is always written before STATUS reads it.
  always_ff @(posedge clk) begin
    if (snap) begin
      shadow[0] <= status_byte;
      shadow[1] <= nonce_q[31:24];
      shadow[2] <= nonce_q[23:16];
      shadow[3] <= nonce_q[15:8];
      shadow[4] <= nonce_q[7:0];
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Scoreboard testbench for spi_cmd_controller: directed frames push expected
// output events (job writes, starts, aborts, transmitted bytes) with their
// expected cycle; a negedge monitor pops and compares whenever the DUT presents one.
module tb_spi_cmd_controller;

  localparam int HDR_BYTES = 76;

  typedef enum logic [1:0] {EV_WE, EV_START, EV_ABORT, EV_TX} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] value;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  sb[$];

  spi_cmd_controller_if #(.HDR_BYTES(HDR_BYTES)) bus ();

  spi_cmd_controller #(.HDR_BYTES(HDR_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [31:0] value, input int at_cyc);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_kind_t kind, input logic [31:0] value);
    ev_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got 0x%0h at cycle %0d, expected no event", kind.name(), value, cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("ev_kind_%s", e.kind.name()), 32'(kind), 32'(e.kind));
      check($sformatf("ev_value_%s", e.kind.name()), value, e.value);
      check($sformatf("ev_cycle_%s", e.kind.name()), cyc, e.cyc);
    end
  endtask

  // Monitor: compare every presented DUT output against the scoreboard head.
  always @(negedge clk) begin
    if (bus.job_we === 1'b1)      observe(EV_WE, {17'd0, bus.job_addr, bus.job_data});
    if (bus.job_start === 1'b1)   observe(EV_START, 32'd0);
    if (bus.miner_abort === 1'b1) observe(EV_ABORT, 32'd0);
    if (bus.tx_req === 1'b1)      observe(EV_TX, {24'd0, bus.tx_byte});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic begin_frame();
    bus.chip_enable = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    bus.chip_enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse_found(input logic [31:0] n);
    bus.miner_found = 1'b1;
    bus.miner_nonce = n;
    tick();
    bus.miner_found = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_byte"},     32'(bus.tx_byte),     32'd0);
    check({tag, "_job_we"},      32'(bus.job_we),      32'd0);
    check({tag, "_job_addr"},    32'(bus.job_addr),    32'd0);
    check({tag, "_job_data"},    32'(bus.job_data),    32'd0);
    check({tag, "_job_start"},   32'(bus.job_start),   32'd0);
    check({tag, "_miner_abort"}, 32'(bus.miner_abort), 32'd0);
  endtask

  // Header bytes base+i; without checksum the start lands two cycles after the last byte.
  task automatic load_full(input logic [7:0] base);
    logic [7:0] d;
    logic [7:0] x;
    x = 8'h00;
    begin_frame();
    send(8'h01);
    for (int i = 0; i < HDR_BYTES; i++) begin
      d = 8'(base + i);
      x = x ^ d;
      expect_ev(EV_WE, {17'd0, 7'(i), d}, cyc + 1);
`ifndef SPI_CMD_CHECKSUM_EN
      if (i == HDR_BYTES - 1) expect_ev(EV_START, 32'd0, cyc + 2);
`endif
      send(d);
    end
`ifdef SPI_CMD_CHECKSUM_EN
    expect_ev(EV_START, 32'd0, cyc + 1);
    send(x);
`else
    if (x == 8'h5A) bus.rx_byte = 8'h00;
`endif
    end_frame();
  endtask

`ifdef SPI_CMD_CHECKSUM_EN
  task automatic load_bad_csum(input logic [7:0] base);
    logic [7:0] d;
    logic [7:0] x;
    x = 8'h00;
    begin_frame();
    send(8'h01);
    for (int i = 0; i < HDR_BYTES; i++) begin
      d = 8'(base + i);
      x = x ^ d;
      expect_ev(EV_WE, {17'd0, 7'(i), d}, cyc + 1);
      send(d);
    end
    send(x ^ 8'h10);
    end_frame();
  endtask
`endif

  // n header bytes, then frame end coincident with one more byte that must be dropped.
  task automatic load_truncated(input int n);
    begin_frame();
    send(8'h01);
    for (int i = 0; i < n; i++) begin
      expect_ev(EV_WE, {17'd0, 7'(i), 8'(8'hA0 + i)}, cyc + 1);
      send(8'(8'hA0 + i));
    end
    bus.chip_enable = 1'b1;
    bus.rx_valid    = 1'b1;
    bus.rx_byte     = 8'hEE;
    tick();
    bus.rx_valid    = 1'b0;
    tick();
  endtask

  // READ_STATUS consuming n_req bytes (bytes_exp is byte0 in the MSBs);
  // optionally a miner_found coincides with the last tx_req.
  task automatic read_status(input logic [39:0] bytes_exp, input int n_req,
                             input bit hit_last, input logic [31:0] hit_nonce);
    begin_frame();
    send(8'h02);
    for (int k = 0; k < n_req; k++) begin
      expect_ev(EV_TX, {24'd0, bytes_exp[39 - 8*k -: 8]}, cyc);
      bus.tx_req = 1'b1;
      if (hit_last && k == n_req - 1) begin
        bus.miner_found = 1'b1;
        bus.miner_nonce = hit_nonce;
      end
      tick();
      bus.tx_req      = 1'b0;
      bus.miner_found = 1'b0;
    end
    end_frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.chip_enable = 1'b1;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.tx_req      = 1'b0;
    bus.miner_busy  = 1'b0;
    bus.miner_found = 1'b0;
    bus.miner_nonce = 32'h0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Full load 0x00..0x4B, then loaded shows in status.
    load_full(8'h00);
    read_status(40'h01_00000000, 5, 1'b0, 32'h0);

    // Found nonce readback; a second read shows found cleared.
    bus.miner_busy = 1'b1;
    pulse_found(32'hDEADBEEF);
    read_status(40'h07_DEADBEEF, 5, 1'b0, 32'h0);
    read_status(40'h03_DEADBEEF, 5, 1'b0, 32'h0);

    // Abort while busy clears loaded.
    begin_frame();
    expect_ev(EV_ABORT, 32'd0, cyc + 1);
    send(8'h03);
    send(8'h01);
    end_frame();
    read_status(40'h02_DEADBEEF, 5, 1'b0, 32'h0);
    bus.miner_busy = 1'b0;

    // Truncated load sets err; a completed readback clears it.
    load_truncated(40);
    read_status(40'h08_DEADBEEF, 5, 1'b0, 32'h0);
    read_status(40'h00_DEADBEEF, 5, 1'b0, 32'h0);

    // Unknown opcode: following bytes produce nothing.
    begin_frame();
    send(8'h7F);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    end_frame();

    // Readback cut short keeps found set.
    pulse_found(32'h12345678);
    read_status(40'h04_12345678, 2, 1'b0, 32'h0);
    read_status(40'h04_12345678, 5, 1'b0, 32'h0);
    read_status(40'h00_12345678, 5, 1'b0, 32'h0);

    // Found coincident with the final tx_req: found stays, new nonce appears next time.
    pulse_found(32'hCAFEBABE);
    read_status(40'h04_CAFEBABE, 5, 1'b1, 32'h11223344);
    read_status(40'h04_11223344, 5, 1'b0, 32'h0);
    read_status(40'h00_11223344, 5, 1'b0, 32'h0);

`ifdef SPI_CMD_CHECKSUM_EN
    load_full(8'h10);
    load_bad_csum(8'h20);
    read_status(40'h09_11223344, 5, 1'b0, 32'h0);
    read_status(40'h01_11223344, 5, 1'b0, 32'h0);
`endif

    // Reset in the middle of a load frame restores every register.
    load_full(8'h80);
    pulse_found(32'h55AA55AA);
    read_status(40'h05_55AA55AA, 1, 1'b0, 32'h0);
    begin_frame();
    send(8'h01);
    for (int i = 0; i < 5; i++) begin
      expect_ev(EV_WE, {17'd0, 7'(i), 8'(8'h30 + i)}, cyc + 1);
      send(8'(8'h30 + i));
    end
    reset = 1'b1;
    tick();
    check_outputs_zero("rst_mid");
    reset = 1'b0;
    read_status(40'h00_00000000, 5, 1'b0, 32'h0);

    repeat (4) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
# spi_cmd_controller

Command sequencer sitting between `spi_slave` and the mining core. Decodes byte frames delimited by `chip_enable` and loads 76-byte block-header jobs into the miner's job buffer. Issues start/abort controls, latches found nonces, and serves a 5-byte status/nonce readback through the SPI transmit path.

## Interface
Parameters:
- `HDR_BYTES`, 76, header bytes per LOAD_JOB (job_addr width = $clog2(HDR_BYTES))

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `chip_enable`  input  1  SPI frame select from `spi_slave`, active low; high = no frame
- `rx_valid`  input  1  one-cycle pulse, `rx_byte` holds a completed received byte
- `rx_byte`  input  8  received byte
- `tx_req`  input  1  one-cycle pulse, `spi_slave` consumed current `tx_byte`
- `tx_byte`  output  8  byte to shift out next
- `miner_busy`  input  1  miner is hashing
- `miner_found`  input  1  one-cycle pulse, `miner_nonce` valid
- `miner_nonce`  input  32  winning nonce
- `job_we`  output  1  job buffer write strobe
- `job_addr`  output  7  job buffer byte address
- `job_data`  output  8  job buffer write data
- `job_start`  output  1  one-cycle pulse: new job fully loaded
- `miner_abort`  output  1  one-cycle pulse: stop current job

## Operation
- States: IDLE, CMD, LOAD, STATUS, DISCARD.
- IDLE: `chip_enable`=1. On `chip_enable`=0, go to CMD.
- CMD: the first `rx_valid` byte is the opcode:
  - 0x01 LOAD_JOB: go to LOAD with byte counter = 0.
  - 0x02 READ_STATUS: snapshot shadow = {status, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0]}, go to STATUS with idx = 0.
  - 0x03 ABORT: pulse `miner_abort`, go to DISCARD.
  - Any other opcode: go to DISCARD.
- LOAD: each `rx_valid` writes `job_addr`=counter, `job_data`=rx_byte, `job_we`=1, then increments the counter.
  - After byte HDR_BYTES-1, pulse `job_start` and go to DISCARD.
  - Bytes received in DISCARD are ignored.
- STATUS:
  - `tx_byte` = shadow[idx]; each `tx_req` increments idx.
  - After idx 4 is consumed, clear `found` and go to DISCARD.
  - While in STATUS, `rx_valid` bytes are ignored.
- Status byte = {4'b0, err, found, miner_busy, loaded}.
  - `loaded` is set by `job_start` and cleared by `miner_abort`.
  - `err` is sticky and is cleared only by a completed READ_STATUS frame.
- `miner_found` latches `miner_nonce` into the nonce register and sets `found`. This happens in every state.
- Frame end: `chip_enable`=1 in any state returns to IDLE on the next edge.
  - If this occurs in LOAD, set `err`; `job_start` is not issued, and bytes already written remain in the buffer.
  - If this occurs in STATUS before idx 4 is consumed, `found` is not cleared.
- `tx_byte` = 0x00 outside STATUS.

## Timing
- Reset values: `tx_byte`=0, `job_we`=0, `job_addr`=0, `job_data`=0, `job_start`=0, `miner_abort`=0. Internal state is IDLE, and err/found/loaded/nonce = 0.
- All outputs are registered.
- `job_we`/`job_addr`/`job_data` assert in the cycle after the `rx_valid` cycle.
- `job_start` asserts in the cycle after the final `job_we`.
- `miner_abort` asserts in the cycle after the opcode `rx_valid`.
- Shadow snapshot is taken on the opcode edge. `tx_byte` shows shadow[0] one cycle after the opcode `rx_valid`, and shows shadow[idx+1] one cycle after each `tx_req`.
- Coincident `miner_found` and final STATUS `tx_req`: `found` stays set (set wins over clear). The nonce register updates; the shadow does not.
- Coincident `chip_enable`=1 and `rx_valid`: the frame end wins, and the byte is dropped.
- A `reset` asserted mid-frame returns the block to the reset state on that edge, regardless of `chip_enable`.

## Configuration
- `SPI_CMD_CHECKSUM_EN` defined:
  - LOAD_JOB expects HDR_BYTES+1 bytes; the last byte is the XOR of all header bytes.
  - The checksum byte is not written to the buffer.
  - On match, pulse `job_start` one cycle after the checksum byte's `rx_valid`.
  - On mismatch, set `err` and issue no `job_start`.
- Not defined:
  - No checksum byte.
  - `job_start` follows the last header byte as described in Timing.

## Test plan
- LOAD_JOB of bytes 0x00..0x4B → 76 `job_we` strobes with addr==data. One `job_start` follows the last write; then READ_STATUS status bit0=1.
- `miner_found` with nonce 0xDEADBEEF, then READ_STATUS → tx sequence 0x04|busy, 0xDE, 0xAD, 0xBE, 0xEF. A second READ_STATUS returns found=0.
- LOAD_JOB with `chip_enable`=1 after 40 bytes → 40 writes, no `job_start`. Next READ_STATUS status = 0x08; the one after returns err=0.
- Opcode 0x03 while `miner_busy` → `miner_abort` pulse one cycle after the opcode, and `loaded`=0. Opcode 0x7F → no outputs, bytes ignored until the frame ends.
- `miner_found` on the same edge as the final STATUS `tx_req` → `found` remains 1, and the next READ_STATUS shows the new nonce.
- With `SPI_CMD_CHECKSUM_EN`: a correct checksum gives `job_start`; a corrupted checksum gives no `job_start`, and status err=1.
